// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer on a valid/ready handshake.
// Flush keeps the low KEEP_W payload bits (PC/EPC); a saturating stall counter supports perf debug.
module pipe_skid_reg #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned KEEP_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Bits of the output entry that survive a flush; all-zero when KEEP_W == 0.
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} >> (WIDTH - KEEP_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  // Port decode depends only on state, so in_ready has no path from out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occ       = state_q;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q & KEEP_MASK;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment, flush leaves it alone.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned W  = 64;
  localparam int unsigned KW = 32;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] KMASK = 64'h0000_0000_FFFF_FFFF;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occ;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of held entries, last output value, stall count.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_stale = '0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(W), .KEEP_W(KW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [W-1:0] e;
    e = (mq.size() > 0) ? mq[0] : m_stale;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    check({tag, ".occ"},       64'(occ),       64'(mq.size()));
    check({tag, ".out_data"},  out_data,       e);
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic model_update(input logic rs, input logic fl, input logic iv,
                              input logic [W-1:0] d, input logic ordy, input logic clr);
    logic ir, ov, inf, outf;
    ir   = (mq.size() < 2);
    ov   = (mq.size() > 0);
    inf  = iv && ir;
    outf = ov && ordy;
    if (rs) begin
      mq.delete();
      m_stale = '0;
      m_cnt   = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (ov && !ordy && m_cnt < CMAX) m_cnt++;
      if (fl) begin
        m_stale = (ov ? mq[0] : m_stale) & KMASK;
        mq.delete();
      end else begin
        if (outf) m_stale = mq.pop_front();
        if (inf) mq.push_back(d);
      end
    end
  endtask

  // One clock: drive at negedge, confirm in_ready ignores out_ready, advance model, return at next negedge.
  task automatic step(input logic rs, input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic ordy, input logic clr);
    reset = rs; flush = fl; in_valid = iv; in_data = d; out_ready = ordy; clr_cnt = clr;
    #1;
    if (!$isunknown(occ)) check("in_ready_comb", 64'(in_ready), 64'(mq.size() < 2));
    model_update(rs, fl, iv, d, ordy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_state("reset");
    check("reset.data0", out_data, 64'h0);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 64'(8'hA0 + i), 1'b1, 1'b0);
      if (i == 0) check("stream.first", out_data, 64'hA0);
      check_state("stream");
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_state("stream.drain");

    // Backpressure into the skid entry.
    step(1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0);
    check_state("bp.one");
    step(1'b0, 1'b0, 1'b1, 64'h22, 1'b0, 1'b0);
    check("bp.occ2", 64'(occ), 64'd2);
    check("bp.in_ready0", 64'(in_ready), 64'd0);
    check("bp.data11", out_data, 64'h11);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("bp.data22", out_data, 64'h22);
    check("bp.in_ready1", 64'(in_ready), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_state("bp.empty");

    // Flush with skid full keeps only the PC field.
    step(1'b0, 1'b0, 1'b1, 64'h8C010004_00003010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 64'h55555555_55555555, 1'b1, 1'b0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.occ", 64'(occ), 64'd0);
    check("flush.data", out_data, 64'h00000000_00003010);
    check_state("flush");
    // A beat offered while ONE and flushing is discarded.
    step(1'b0, 1'b0, 1'b1, 64'h12345678_00004000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 64'h77777777_77777777, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("flush.killed", 64'(out_valid), 64'd0);
    check("flush.keep2", out_data, 64'h00000000_00004000);

    // Reset beats flush: low bits cleared too.
    step(1'b0, 1'b0, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'hCCCCCCCC_DDDDDDDD, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rstflush.data", out_data, 64'h0);
    check_state("rstflush");

    // Stall counter saturation and clear.
    step(1'b0, 1'b0, 1'b1, 64'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("stall.sat", 64'(stall_cnt), 64'd15);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("stall.clr", 64'(stall_cnt), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("stall.resume", 64'(stall_cnt), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("flushclr.cnt", 64'(stall_cnt), 64'd0);
    check("flushclr.data", out_data, 64'h77);
    check_state("flushclr");

    // Random traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      logic rs, fl, iv, ordy, clr;
      logic [W-1:0] d;
      rs   = ($urandom_range(0, 999) == 0);
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 99) < 65);
      ordy = ($urandom_range(0, 99) < 60);
      clr  = ($urandom_range(0, 99) == 0);
      d    = {$urandom, $urandom};
      step(rs, fl, iv, d, ordy, clr);
      check_state("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised successor to the fixed five-field inter-stage pipeline registers (D/E/M/W). It carries an arbitrary-width stage payload over a valid/ready handshake. A 2-entry skid buffer lets upstream stall logic be registered rather than combinational. Flush clears the stage but retains a low PC field for exception/EPC use. It sits between any two pipeline stages, and also keeps a saturating per-stage stall-cycle counter for performance debug.

Parameters:
WIDTH, 160, total payload bits (e.g. PC, Instr, Rt_data, C, MDU_C concatenated, PC in bits [31:0]).
KEEP_W, 32, low payload bits of the output entry preserved on flush (0..WIDTH).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous stage flush.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts.
out_data  out  WIDTH  output entry payload.
occ  out  2  occupancy: 0, 1 or 2.
clr_cnt  in  1  synchronous clear of stall_cnt.
stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage: main register (drives out_data), skid register, state in {EMPTY, ONE, FULL}.
- Port decode: out_valid = (state != EMPTY); in_ready = (state != FULL); occ = 0/1/2 for EMPTY/ONE/FULL.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data must not change except on these events.
- EMPTY: in_fire -> main <= in_data, go ONE.
- ONE, in_fire & out_fire: main <= in_data, stay ONE.
- ONE, in_fire & !out_fire: skid <= in_data, go FULL.
- ONE, !in_fire & out_fire: go EMPTY; main holds its stale value.
- ONE, neither: hold.
- FULL: out_fire -> main <= skid, go ONE. No in_fire is possible since in_ready = 0.
- Latency: 1 cycle from in_fire (while EMPTY) to out_valid. Sustained throughput: 1 per cycle when out_ready is held high. Ordering is strictly FIFO.
- Flush (priority below reset, above handshake):
  - state -> EMPTY.
  - main[WIDTH-1:KEEP_W] <= 0; main[KEEP_W-1:0] holds.
  - skid <= 0.
  - Any in_fire or out_fire in the flush cycle is discarded; upstream must treat its beat as killed.
  - Next cycle: in_ready = 1, out_valid = 0.
- Reset (highest priority):
  - main, skid, state -> 0/EMPTY; stall_cnt -> 0.
  - Output values after reset: out_valid = 0, in_ready = 1, out_data = 0, occ = 0, stall_cnt = 0.
  - Reset mid-transfer drops all entries.
- Stall counter:
  - Increments each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt -> 0 next cycle; clr_cnt has priority over increment.
  - Flush does not affect stall_cnt.
- Boundaries:
  - KEEP_W = 0: flush zeroes all of main.
  - KEEP_W = WIDTH: flush retains all of main.
  - Simultaneous flush and clr_cnt: both take effect.
  - WIDTH >= 1 required; CNT_W >= 1.
- No X on outputs after the first reset cycle.

Test Plan:
- Reset then stream: hold reset 2 cycles; send 0xA0..0xA7 in low bits with out_ready = 1 -> out_valid rises 1 cycle after the first in_fire; outputs arrive in order, 1 per cycle; occ stays 1; stall_cnt = 0.
- Backpressure/skid: while ONE holding 0x11, drop out_ready and send 0x22 -> occ = 2, in_ready = 0 next cycle, out_data = 0x11. Raise out_ready -> 0x11 then 0x22 delivered, in_ready returns 1 after the first out_fire.
- Flush with retained PC:
  - Setup: main = {Instr=0x8C010004, PC=0x00003010}, skid full.
  - Stimulus: pulse flush.
  - Required: out_valid = 0, occ = 0, out_data[31:0] = 0x00003010, upper bits = 0.
  - Required: a beat offered in the flush cycle never appears at the output.
- Flush vs reset priority: assert reset and flush together while FULL -> out_data = 0 entirely, including the low KEEP_W bits.
- Stall counter: CNT_W = 4, hold out_valid with out_ready = 0 for 20 cycles -> stall_cnt reaches 15 and stays. Pulse clr_cnt in a stalled cycle -> 0 next cycle, then counting resumes at 1.
- Random equivalence: 10k cycles of random in_valid/out_ready/flush -> output sequence matches a reference queue model. No data loss or duplication between flushes; in_ready never depends combinationally on out_ready.
